// File: rtl/multicycle_alu.sv
// Handshaked ALU: logic, add/sub, compare and shift ops finish in one cycle;
// shift-add multiply and restoring divide iterate one bit per cycle.
module multicycle_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [3:0]            ALUop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Overflow,
    output logic                  CarryOut,
    output logic                  Zero,
    output logic                  DivZero,
    output logic [1:0]            dbg_state_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [2*W-1:0]     acc_q, acc_d;
    logic [W-1:0]       opnd_q;
    logic               is_div_q, hi_sel_q;
    logic [W-1:0]       res_q;
    logic               ovf_q, cout_q, zero_q, divz_q;

    logic               accept, long_in, last_step;
    logic [SHAMT_W-1:0] shamt;
    logic [W:0]         sum_w, diff_w;
    logic [W-1:0]       sc_res;
    logic               sc_ovf, sc_cout;
    logic [W:0]         mul_sum, div_part;
    logic               div_ge;
    logic [W-1:0]       long_res;

    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // a result transfers on an edge where out_valid && out_ready. Both sides hold
    // their payload stable until the transfer edge.
    assign accept    = in_valid & in_ready;
    assign long_in   = ALUop[3] & ALUop[2];
    assign last_step = (cnt_q == LAST);
    assign shamt     = B[SHAMT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = long_in ? BUSY : DONE;
            BUSY: if (last_step) state_d = DONE;
            DONE: if (out_ready) begin
                if (in_valid) state_d = long_in ? BUSY : DONE;
                else          state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: in_ready = rst;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = rst & out_ready;
            end
            default: ;
        endcase
    end

    assign sum_w  = {1'b0, A} + {1'b0, B};
    assign diff_w = {1'b0, A} - {1'b0, B};

    always_comb begin
        sc_res  = '0;
        sc_ovf  = 1'b0;
        sc_cout = 1'b0;
        case (ALUop)
            4'b0000: sc_res = A & B;
            4'b0001: sc_res = A | B;
            4'b0010: begin
                sc_res  = sum_w[W-1:0];
                sc_cout = sum_w[W];
                sc_ovf  = (A[W-1] == B[W-1]) && (sum_w[W-1] != A[W-1]);
            end
            4'b0110: begin
                sc_res  = diff_w[W-1:0];
                sc_cout = diff_w[W];
                sc_ovf  = (A[W-1] != B[W-1]) && (diff_w[W-1] != A[W-1]);
            end
            4'b0111: sc_res = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
            4'b0011: sc_res = {{(W-1){1'b0}}, (A < B)};
            4'b0100: sc_res = A ^ B;
            4'b0101: sc_res = ~(A | B);
            4'b1000: sc_res = A << shamt;
            4'b1001: sc_res = A >> shamt;
            4'b1010: sc_res = $unsigned($signed(A) >>> shamt);
            default: sc_res = '0;
        endcase
    end

    // acc_q holds {hi, lo} for multiply and {remainder, quotient} for divide.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q & {W{acc_q[0]}}};
    assign div_part = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_ge   = (div_part >= {1'b0, opnd_q});

    always_comb begin
        if (is_div_q) begin
            if (div_ge) acc_d = {div_part[W-1:0] - opnd_q, acc_q[W-2:0], 1'b1};
            else        acc_d = {acc_q[2*W-2:0], 1'b0};
        end else begin
            acc_d = {mul_sum, acc_q[W-1:1]};
        end
    end

    assign long_res = hi_sel_q ? acc_d[2*W-1:W] : acc_d[W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            hi_sel_q <= 1'b0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
            divz_q   <= 1'b0;
        end else if (accept) begin
            cnt_q    <= '0;
            is_div_q <= ALUop[1];
            hi_sel_q <= ALUop[0];
            if (long_in) begin
                opnd_q <= ALUop[1] ? B : A;
                acc_q  <= {{W{1'b0}}, (ALUop[1] ? A : B)};
            end else begin
                res_q  <= sc_res;
                ovf_q  <= sc_ovf;
                cout_q <= sc_cout;
                // The reserved code reports every flag clear, Zero included.
                zero_q <= (sc_res == '0) && (ALUop != 4'b1011);
                divz_q <= 1'b0;
            end
        end else if (state_q == BUSY) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (last_step) begin
                res_q  <= long_res;
                ovf_q  <= 1'b0;
                cout_q <= 1'b0;
                zero_q <= (long_res == '0);
                divz_q <= is_div_q && (opnd_q == '0);
            end
        end
    end

    assign Result      = res_q;
    assign Overflow    = ovf_q;
    assign CarryOut    = cout_q;
    assign Zero        = zero_q;
    assign DivZero     = divz_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: a 32-bit and an 8-bit instance driven with directed
// and random operations, checked against an arithmetic reference model.
module tb_multicycle_alu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  iv, ordy;
    logic [31:0] a0, b0;
    logic [7:0]  a8, b8;
    logic [3:0]  op_i [2];
    logic        ir0, ir1, ov0, ov1, ovf0, ovf1, co0, co1, z0, z1, dz0, dz1;
    logic [31:0] res0;
    logic [7:0]  res8;
    logic [1:0]  st0, st1;
    logic [1:0]  ir, ov, ovf, co, zr, dz;
    int          n_checks = 0;
    int          n_errors = 0;

    assign ir  = {ir1, ir0};
    assign ov  = {ov1, ov0};
    assign ovf = {ovf1, ovf0};
    assign co  = {co1, co0};
    assign zr  = {z1, z0};
    assign dz  = {dz1, dz0};

    multicycle_alu #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .A(a0), .B(b0),
        .ALUop(op_i[0]), .out_valid(ov0), .out_ready(ordy[0]), .Result(res0),
        .Overflow(ovf0), .CarryOut(co0), .Zero(z0), .DivZero(dz0), .dbg_state_o(st0)
    );

    multicycle_alu #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .A(a8), .B(b8),
        .ALUop(op_i[1]), .out_valid(ov1), .out_ready(ordy[1]), .Result(res8),
        .Overflow(ovf1), .CarryOut(co1), .Zero(z1), .DivZero(dz1), .dbg_state_o(st1)
    );

    function automatic logic [31:0] res_of(input int d);
        return (d == 1) ? {24'd0, res8} : res0;
    endfunction

    function automatic logic [1:0] st_of(input int d);
        return (d == 1) ? st1 : st0;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        if (d == 1) begin
            a8 = a[7:0];
            b8 = b[7:0];
        end else begin
            a0 = a;
            b0 = b;
        end
        op_i[d] = op;
    endtask

    // Reference: true integer arithmetic on values reduced to w bits.
    function automatic void model(input int w, input logic [3:0] op, input logic [31:0] a_in,
                                  input logic [31:0] b_in, output logic [31:0] r,
                                  output logic o, output logic c, output logic z, output logic dzv);
        longint unsigned mask, a, b, rr;
        longint          sa, sb, s, maxp;
        int              sh;
        mask = (64'd1 << w) - 64'd1;
        a    = {32'd0, a_in} & mask;
        b    = {32'd0, b_in} & mask;
        sa   = a[w-1] ? longint'(a) - longint'(mask) - 64'sd1 : longint'(a);
        sb   = b[w-1] ? longint'(b) - longint'(mask) - 64'sd1 : longint'(b);
        maxp = longint'(mask >> 1);
        sh   = int'(b % longint'(w));
        o = 1'b0; c = 1'b0; dzv = 1'b0; rr = 0;
        case (op)
            4'h0: rr = a & b;
            4'h1: rr = a | b;
            4'h2: begin
                rr = (a + b) & mask;
                c  = ((a + b) >> w) != 0;
                s  = sa + sb;
                o  = (s > maxp) || (s < -maxp - 1);
            end
            4'h6: begin
                rr = (a - b) & mask;
                c  = a < b;
                s  = sa - sb;
                o  = (s > maxp) || (s < -maxp - 1);
            end
            4'h7: rr = (sa < sb) ? 1 : 0;
            4'h3: rr = (a < b) ? 1 : 0;
            4'h4: rr = a ^ b;
            4'h5: rr = ~(a | b) & mask;
            4'h8: rr = (a << sh) & mask;
            4'h9: rr = a >> sh;
            4'hA: begin
                rr = sa >>> sh;
                rr = rr & mask;
            end
            4'hC: rr = (a * b) & mask;
            4'hD: rr = ((a * b) >> w) & mask;
            4'hE: rr = (b == 0) ? mask : a / b;
            4'hF: rr = (b == 0) ? a : a % b;
            default: rr = 0;
        endcase
        r   = rr[31:0];
        z   = (rr == 0) && (op != 4'hB);
        dzv = (op == 4'hE || op == 4'hF) && (b == 0);
    endfunction

    function automatic logic [31:0] rnd_val(input int w);
        case ($urandom_range(0, 4))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 15));
            3: return (w == 8) ? 32'h80 : 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Issues one op (b2b: we sit at a negedge in DONE and take the old result
    // on the same edge), measures latency, checks outputs and stall hold.
    task automatic do_op(input int d, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int stall, input bit b2b,
                         output logic [31:0] got);
        int          w, lat, n, exp_lat;
        logic [31:0] er;
        logic        eo, ec, ez, edz;
        w = (d == 1) ? 8 : 32;
        model(w, op, a, b, er, eo, ec, ez, edz);
        exp_lat = (op[3:2] == 2'b11) ? w + 1 : 1;
        if (b2b) ordy[d] = 1'b1;
        else     @(negedge clk);
        drive(d, a, b, op);
        iv[d] = 1'b1;
        #1;
        if (b2b) check($sformatf("b2b_ready d%0d", d), ir[d], 1);
        n = 0;
        while (!ir[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("accept_ready d%0d", d), ir[d], 1);
        @(posedge clk);
        #1;
        iv[d]   = 1'b0;
        ordy[d] = 1'b0;
        drive(d, $urandom, $urandom, 4'($urandom));
        lat = 1;
        @(negedge clk);
        while (!ov[d] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency d%0d op%0h", d, op), lat, exp_lat);
        got = res_of(d);
        check($sformatf("result d%0d op%0h a%0h b%0h", d, op, a, b), got, er);
        check($sformatf("overflow d%0d op%0h", d, op), ovf[d], eo);
        check($sformatf("carry d%0d op%0h", d, op), co[d], ec);
        check($sformatf("zero d%0d op%0h", d, op), zr[d], ez);
        check($sformatf("divzero d%0d op%0h", d, op), dz[d], edz);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check($sformatf("hold_result d%0d", d), res_of(d), er);
            check($sformatf("hold_valid d%0d", d), ov[d], 1);
            check($sformatf("hold_ready d%0d", d), ir[d], 0);
        end
    endtask

    task automatic release_out(input int d);
        @(negedge clk);
        ordy[d] = 1'b1;
        @(posedge clk);
        #1;
        ordy[d] = 1'b0;
        @(negedge clk);
        check($sformatf("released d%0d", d), ov[d], 0);
    endtask

    task automatic directed(input int d, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] want, input string tag);
        logic [31:0] got;
        do_op(d, op, a, b, 0, 1'b0, got);
        check(tag, got, want);
        release_out(d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, a, b;
        logic [3:0]  op;
        bit          b2b;
        int          seen;
        rst = 1'b0; iv = '0; ordy = '0;
        a0 = '0; b0 = '0; a8 = '0; b8 = '0;
        op_i[0] = '0; op_i[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_result d%0d", d), res_of(d), 0);
            check($sformatf("rst_valid d%0d", d), ov[d], 0);
            check($sformatf("rst_zero d%0d", d), zr[d], 1);
            check($sformatf("rst_flags d%0d", d), {ovf[d], co[d], dz[d]}, 0);
            check($sformatf("rst_ready d%0d", d), ir[d], 0);
            check($sformatf("rst_state d%0d", d), st_of(d), 0);
        end
        rst = 1'b1;
        #1;
        check("ready_after_rst d0", ir[0], 1);
        check("ready_after_rst d1", ir[1], 1);

        directed(0, 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, "plan add");
        directed(0, 4'b0110, 32'd1, 32'd2, 32'hFFFF_FFFF, "plan sub");
        directed(0, 4'b0111, 32'h8000_0000, 32'd1, 32'd1, "plan slt");
        directed(0, 4'b0011, 32'h8000_0000, 32'd1, 32'd0, "plan sltu");
        directed(0, 4'b1010, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, "plan sra");
        directed(0, 4'b1000, 32'd1, 32'h21, 32'd2, "plan sll");
        directed(0, 4'b1100, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "plan mul");
        directed(0, 4'b1101, 32'hFFFF_FFFF, 32'd2, 32'd1, "plan mulhu");
        directed(0, 4'b1011, 32'h1234_5678, 32'h9, 32'd0, "plan reserved");
        directed(1, 4'b1110, 32'd200, 32'd7, 32'd28, "plan divu");
        directed(1, 4'b1111, 32'd200, 32'd7, 32'd4, "plan remu");
        directed(1, 4'b1110, 32'd100, 32'd0, 32'hFF, "plan divu0");
        directed(1, 4'b1111, 32'd5, 32'd0, 32'd5, "plan remu0");

        do_op(0, 4'b0010, 32'd10, 32'd20, 5, 1'b0, got);
        do_op(0, 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b1, got);
        check("b2b and", got, 32'h00F0_1200);
        release_out(0);

        for (int d = 0; d < 2; d++) begin
            b2b = 1'b0;
            for (int k = 0; k < 30; k++) begin
                op = 4'($urandom_range(0, 15));
                a  = rnd_val((d == 1) ? 8 : 32);
                b  = rnd_val((d == 1) ? 8 : 32);
                do_op(d, op, a, b, $urandom_range(0, 3), b2b, got);
                b2b = 1'($urandom_range(0, 1));
                if (!b2b) release_out(d);
            end
            if (b2b) release_out(d);
        end

        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            drive(d, 32'd200, 32'd7, 4'b1110);
            iv[d] = 1'b1;
            @(posedge clk);
            #1;
            iv[d] = 1'b0;
            repeat (9) @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("abort_valid d%0d", d), ov[d], 0);
            check($sformatf("abort_zero d%0d", d), zr[d], 1);
            check($sformatf("abort_state d%0d", d), st_of(d), 0);
            check($sformatf("abort_ready_low d%0d", d), ir[d], 0);
            @(negedge clk);
            rst = 1'b1;
            #1;
            check($sformatf("abort_ready d%0d", d), ir[d], 1);
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (ov[d]) seen++;
            end
            check($sformatf("abort_no_pulse d%0d", d), seen, 0);
            directed(d, 4'b0010, 32'd2, 32'd3, 32'd5, $sformatf("after_abort add d%0d", d));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
